demux_4x_nbit_stream: RTL and testbench
=======================================

Name: demux_4x_nbit_stream

Overview:
- 1-to-4 stream demultiplexer: the distribution side of the 4:1 N-bit mux datapath.
- One N-bit valid/ready input stream carries a 2-bit destination select per word. Each word is routed to one of four output streams.
- Each output has a 2-entry elastic buffer, so a stalled output blocks only words addressed to it.
- Per-output saturating transfer counters give debug and throughput visibility.

Parameters:
- BUS_WIDTH, 8, data width of input and each output.
- CNT_WIDTH, 8, width of each per-output transfer counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept the word addressed by in_sel.
- in_data  input  BUS_WIDTH  input word.
- in_sel  input  2  destination: 0=a, 1=b, 2=c, 3=d.
- out_valid  output  4  per-output valid; bit k = output k (a=0..d=3).
- out_ready  input  4  per-output ready from consumers.
- a, b, c, d  output  BUS_WIDTH each  head-of-buffer data for outputs 0..3.
- cnt_clr  input  1  synchronous clear of all counters.
- cnt_a, cnt_b, cnt_c, cnt_d  output  CNT_WIDTH each  completed output transfers per channel.

Behaviour:
- Reset (rst=1 at edge): all buffers emptied; out_valid=4'b0000; a..d=0; cnt_*=0.
  - Reset mid-operation silently drops buffered words.
  - in_ready is 0 during the reset cycle.
- Accept: the input is accepted when in_valid && in_ready at a rising edge.
  - in_ready = !rst && (occupancy[in_sel] < 2).
  - in_ready is combinational from in_sel and buffer state only. It has no path from out_ready.
- Routing: an accepted word is pushed only into buffer in_sel. The other buffers are unaffected.
- Latency: a word accepted at edge N is visible on its output (out_valid[k]=1, data valid) after edge N, even into an empty buffer. There is no combinational bypass.
- Output: out_valid[k] = occupancy[k] != 0; data output k = oldest entry.
  - Transfer on output k when out_valid[k] && out_ready[k] at an edge.
  - Per-output order is strictly FIFO.
  - Data is held stable while out_valid[k]=1 and out_ready[k]=0.
- Simultaneous push and pop on the same buffer:
  - occupancy 1: occupancy stays 1; the new word becomes head after the edge.
  - occupancy 2: push is impossible because in_ready=0; pop proceeds and occupancy becomes 1. in_ready rises the next cycle.
  - occupancy 0: pop is impossible; push proceeds.
- Empty output: data output holds its last value (0 after reset). Consumers must qualify data with out_valid.
- in_valid=0: in_sel and in_data are don't-care; nothing is pushed.
- Counters: cnt_k += 1 on each output-k transfer and saturates at 2^CNT_WIDTH-1.
  - cnt_clr=1 sets all counters to 0. cnt_clr overrides a same-cycle transfer, so the result is 0.
- Throughput: an output with out_ready held high sustains 1 word/cycle.

Decomposition:
- Shared package mux_pkg:
  - select encoding constants SEL_A=2'd0, SEL_B=2'd1, SEL_C=2'd2, SEL_D=2'd3;
  - NUM_PORTS=4;
  - BUF_DEPTH=2.
- Sub-module stream_buf_2x_nbit (params BUS_WIDTH):
  - 2-entry register FIFO with push/pop, full, valid, head outputs;
  - instantiated four times.
- Top contains the select decode, the in_ready mux, and the counters.

Test Plan:
- Reset, then in_valid=1, sel=2, data=8'h5A, out_ready=4'b1111: after one edge out_valid=4'b0100, c=8'h5A; the next edge transfers it, cnt_c=1, out_valid=0.
- Hold out_ready[0]=0 and push 8'h11, 8'h22, 8'h33 to sel=0: in_ready drops after the second accept; 8'h33 is held. Push 8'h44 to sel=1 in the next cycle: it is accepted and appears on b.
- Release out_ready[0]=1 in the previous scenario: a shows 8'h11 then 8'h22. in_ready for sel=0 returns the cycle after the first pop; 8'h33 follows in order. cnt_a=3.
- Occupancy 1 on output 3 with out_ready[3]=1 and push 8'hA5: the pop and push occur at the same edge, d=8'hA5, out_valid[3] stays 1, with no loss or duplication.
- Random 200-word stream with random sel and random out_ready: a per-channel scoreboard matches order and data, and cnt_* equals per-channel counts (CNT_WIDTH=4 checks saturation at 15).
- Assert rst with 2 words buffered on b and cnt_b=5: after the edge out_valid=0 and cnt_b=0. Assert cnt_clr concurrent with a transfer: the counter reads 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the 4-way stream demultiplexer datapath.
// Select encoding, port count and per-output buffer depth live here.
package mux_pkg;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  localparam int NUM_PORTS = 4;
  localparam int BUF_DEPTH = 2;

  // One-hot destination decode of a 2-bit select.
  function automatic logic [NUM_PORTS-1:0] sel_decode(input logic [1:0] sel);
    logic [NUM_PORTS-1:0] onehot;
    case (sel)
      SEL_A:   onehot = 4'b0001;
      SEL_B:   onehot = 4'b0010;
      SEL_C:   onehot = 4'b0100;
      SEL_D:   onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/demux_4x_nbit_stream_if.sv
// Stream bundle of the demultiplexer: one selected input stream and four output streams.
// slave = demultiplexer side, master = producer/consumer side.
interface demux_4x_nbit_stream_if #(
  parameter int BUS_WIDTH = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic [BUS_WIDTH-1:0] in_data;
  logic [1:0]           in_sel;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [BUS_WIDTH-1:0] a;
  logic [BUS_WIDTH-1:0] b;
  logic [BUS_WIDTH-1:0] c;
  logic [BUS_WIDTH-1:0] d;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, a, b, c, d
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, a, b, c, d
  );

endinterface

// File: rtl/stream_buf_2x_nbit.sv
// Two-entry register FIFO; entry 0 is always the head and drives head_o directly.
// An empty buffer keeps its last head value.
module stream_buf_2x_nbit
  import mux_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [BUS_WIDTH-1:0] push_data_i,
  input  logic                 pop_i,
  output logic                 full_o,
  output logic                 valid_o,
  output logic [BUS_WIDTH-1:0] head_o
);

  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  logic [BUS_WIDTH-1:0] mem0_q, mem0_d;
  logic [BUS_WIDTH-1:0] mem1_q, mem1_d;
  logic [1:0]           occ_q, occ_d;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  assign push_ok_s = push_i && (occ_q != DEPTH);
  assign pop_ok_s  = pop_i && (occ_q != 2'd0);

  // Next-state of storage and occupancy for push, pop, or both together.
  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    occ_d  = occ_q;
    case ({push_ok_s, pop_ok_s})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) begin
          mem0_d = push_data_i;
        end else begin
          mem1_d = push_data_i;
        end
      end
      2'b01: begin
        occ_d = occ_q - 2'd1;
        if (occ_q == DEPTH) begin
          mem0_d = mem1_q;
        end else begin
          mem0_d = mem0_q;
        end
      end
      // Both only possible at occupancy 1: the new word replaces the head.
      2'b11: begin
        mem0_d = push_data_i;
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Storage and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_q <= {BUS_WIDTH{1'b0}};
      mem1_q <= {BUS_WIDTH{1'b0}};
      occ_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      occ_q  <= occ_d;
    end
  end

  assign full_o  = (occ_q == DEPTH);
  assign valid_o = (occ_q != 2'd0);
  assign head_o  = mem0_q;

endmodule

// File: rtl/demux_4x_nbit_stream.sv
// 1-to-4 stream demultiplexer: routes each input word to the buffer named by in_sel
// and counts completed transfers per output with saturating counters.
module demux_4x_nbit_stream
  import mux_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_4x_nbit_stream_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] cnt_a,
  output logic [CNT_WIDTH-1:0] cnt_b,
  output logic [CNT_WIDTH-1:0] cnt_c,
  output logic [CNT_WIDTH-1:0] cnt_d
);

  logic [NUM_PORTS-1:0] full_s;
  logic [NUM_PORTS-1:0] valid_s;
  logic [NUM_PORTS-1:0] push_s;
  logic [NUM_PORTS-1:0] pop_s;
  logic [BUS_WIDTH-1:0] head_s [NUM_PORTS];
  logic                 accept_s;
  logic [CNT_WIDTH-1:0] xfer_cnt_q [NUM_PORTS];
  logic [CNT_WIDTH-1:0] xfer_cnt_d [NUM_PORTS];

  // Readiness depends only on the addressed buffer's fill level, never on out_ready.
  assign bus.in_ready = !rst && !full_s[bus.in_sel];
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign push_s       = accept_s ? sel_decode(bus.in_sel) : 4'b0000;
  assign pop_s        = valid_s & bus.out_ready;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_buf
    stream_buf_2x_nbit #(
      .BUS_WIDTH(BUS_WIDTH)
    ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push_s[k]),
      .push_data_i(bus.in_data),
      .pop_i      (pop_s[k]),
      .full_o     (full_s[k]),
      .valid_o    (valid_s[k]),
      .head_o     (head_s[k])
    );
  end

  assign bus.out_valid = valid_s;
  assign bus.a         = head_s[SEL_A];
  assign bus.b         = head_s[SEL_B];
  assign bus.c         = head_s[SEL_C];
  assign bus.d         = head_s[SEL_D];

  // Saturating transfer counters; a clear wins over a same-cycle transfer.
  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      xfer_cnt_d[k] = xfer_cnt_q[k];
      if (cnt_clr) begin
        xfer_cnt_d[k] = {CNT_WIDTH{1'b0}};
      end else if (pop_s[k] && (xfer_cnt_q[k] != {CNT_WIDTH{1'b1}})) begin
        xfer_cnt_d[k] = xfer_cnt_q[k] + CNT_WIDTH'(1);
      end else begin
        xfer_cnt_d[k] = xfer_cnt_q[k];
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (rst) begin
        xfer_cnt_q[k] <= {CNT_WIDTH{1'b0}};
      end else begin
        xfer_cnt_q[k] <= xfer_cnt_d[k];
      end
    end
  end

  assign cnt_a = xfer_cnt_q[SEL_A];
  assign cnt_b = xfer_cnt_q[SEL_B];
  assign cnt_c = xfer_cnt_q[SEL_C];
  assign cnt_d = xfer_cnt_q[SEL_D];

endmodule

// File: tb/tb_demux_4x_nbit_stream.sv
// Bench for demux_4x_nbit_stream: directed vector table, then a random stream
// checked against a queue-based per-channel model (CNT_WIDTH=4 to reach saturation).
module tb_demux_4x_nbit_stream;

  localparam int BW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cnt_clr;
  logic [CW-1:0] cnt_a, cnt_b, cnt_c, cnt_d;

  demux_4x_nbit_stream_if #(.BUS_WIDTH(BW)) bus ();

  demux_4x_nbit_stream #(
    .BUS_WIDTH(BW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .cnt_clr(cnt_clr),
    .cnt_a  (cnt_a),
    .cnt_b  (cnt_b),
    .cnt_c  (cnt_c),
    .cnt_d  (cnt_d)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: one FIFO queue per output, last shown head, transfer counts.
  logic [BW-1:0] mq [4][$];
  logic [BW-1:0] last_head [4];
  int            mcnt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic cycle(output logic acc);
    logic [3:0] pp;
    acc = bus.in_valid && !rst && (mq[bus.in_sel].size() < 2);
    for (int k = 0; k < 4; k++) pp[k] = (mq[k].size() != 0) && bus.out_ready[k];
    @(posedge clk);
    #1;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete();
        last_head[k] = '0;
        mcnt[k] = 0;
      end
      acc = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (pp[k]) void'(mq[k].pop_front());
        if (cnt_clr) mcnt[k] = 0;
        else if (pp[k] && mcnt[k] < (2 ** CW) - 1) mcnt[k]++;
      end
      if (acc) mq[bus.in_sel].push_back(bus.in_data);
      for (int k = 0; k < 4; k++) if (mq[k].size() != 0) last_head[k] = mq[k][0];
    end
  endtask

  task automatic model_compare(input string tag);
    logic [3:0] eov;
    for (int k = 0; k < 4; k++) eov[k] = (mq[k].size() != 0);
    chk({tag, "_ov"}, {28'd0, bus.out_valid}, {28'd0, eov});
    chk({tag, "_data"}, {bus.d, bus.c, bus.b, bus.a},
        {last_head[3], last_head[2], last_head[1], last_head[0]});
    chk({tag, "_cnt"}, {16'd0, cnt_d, cnt_c, cnt_b, cnt_a},
        {16'd0, 4'(mcnt[3]), 4'(mcnt[2]), 4'(mcnt[1]), 4'(mcnt[0])});
  endtask

  typedef struct {
    logic          r;
    logic          iv;
    logic [1:0]    sel;
    logic [BW-1:0] data;
    logic [3:0]    ordy;
    logic          clr;
    logic          exp_rdy;
    logic [3:0]    exp_ov;
    logic [31:0]   exp_data;  // {d,c,b,a}
    logic [15:0]   exp_cnt;   // {d,c,b,a}
  } vec_t;

  function automatic vec_t mk(logic r, logic iv, logic [1:0] s, logic [7:0] dt, logic [3:0] o,
                              logic clr, logic er, logic [3:0] eov, logic [31:0] ed,
                              logic [15:0] ec);
    vec_t v;
    v.r = r; v.iv = iv; v.sel = s; v.data = dt; v.ordy = o; v.clr = clr;
    v.exp_rdy = er; v.exp_ov = eov; v.exp_data = ed; v.exp_cnt = ec;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[22];
    logic acc;
    int   words;
    int   cyc;

    tv[0]  = mk(1'b1, 1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b0, 4'h0, 32'h00000000, 16'h0000);
    tv[1]  = mk(1'b0, 1'b1, 2'd2, 8'h5A, 4'hF, 1'b0, 1'b1, 4'h4, 32'h005A0000, 16'h0000);
    tv[2]  = mk(1'b0, 1'b0, 2'd2, 8'h00, 4'hF, 1'b0, 1'b1, 4'h0, 32'h005A0000, 16'h0100);
    tv[3]  = mk(1'b0, 1'b1, 2'd0, 8'h11, 4'hE, 1'b0, 1'b1, 4'h1, 32'h005A0011, 16'h0100);
    tv[4]  = mk(1'b0, 1'b1, 2'd0, 8'h22, 4'hE, 1'b0, 1'b1, 4'h1, 32'h005A0011, 16'h0100);
    tv[5]  = mk(1'b0, 1'b1, 2'd0, 8'h33, 4'hE, 1'b0, 1'b0, 4'h1, 32'h005A0011, 16'h0100);
    tv[6]  = mk(1'b0, 1'b1, 2'd1, 8'h44, 4'hE, 1'b0, 1'b1, 4'h3, 32'h005A4411, 16'h0100);
    tv[7]  = mk(1'b0, 1'b1, 2'd0, 8'h33, 4'hF, 1'b0, 1'b0, 4'h1, 32'h005A4422, 16'h0111);
    tv[8]  = mk(1'b0, 1'b1, 2'd0, 8'h33, 4'hF, 1'b0, 1'b1, 4'h1, 32'h005A4433, 16'h0112);
    tv[9]  = mk(1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b1, 4'h0, 32'h005A4433, 16'h0113);
    tv[10] = mk(1'b0, 1'b1, 2'd3, 8'h5C, 4'h7, 1'b0, 1'b1, 4'h8, 32'h5C5A4433, 16'h0113);
    tv[11] = mk(1'b0, 1'b1, 2'd3, 8'hA5, 4'hF, 1'b0, 1'b1, 4'h8, 32'hA55A4433, 16'h1113);
    tv[12] = mk(1'b0, 1'b0, 2'd3, 8'h00, 4'hF, 1'b0, 1'b1, 4'h0, 32'hA55A4433, 16'h2113);
    tv[13] = mk(1'b0, 1'b1, 2'd1, 8'h01, 4'hF, 1'b0, 1'b1, 4'h2, 32'hA55A0133, 16'h2113);
    tv[14] = mk(1'b0, 1'b1, 2'd1, 8'h02, 4'hF, 1'b0, 1'b1, 4'h2, 32'hA55A0233, 16'h2123);
    tv[15] = mk(1'b0, 1'b1, 2'd1, 8'h03, 4'hF, 1'b0, 1'b1, 4'h2, 32'hA55A0333, 16'h2133);
    tv[16] = mk(1'b0, 1'b1, 2'd1, 8'h04, 4'hF, 1'b0, 1'b1, 4'h2, 32'hA55A0433, 16'h2143);
    tv[17] = mk(1'b0, 1'b1, 2'd1, 8'h05, 4'hF, 1'b0, 1'b1, 4'h2, 32'hA55A0533, 16'h2153);
    tv[18] = mk(1'b0, 1'b1, 2'd1, 8'h06, 4'hD, 1'b0, 1'b1, 4'h2, 32'hA55A0533, 16'h2153);
    tv[19] = mk(1'b1, 1'b1, 2'd1, 8'h07, 4'hF, 1'b0, 1'b0, 4'h0, 32'h00000000, 16'h0000);
    tv[20] = mk(1'b0, 1'b1, 2'd0, 8'h77, 4'hF, 1'b0, 1'b1, 4'h1, 32'h00000077, 16'h0000);
    tv[21] = mk(1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 1'b1, 4'h0, 32'h00000077, 16'h0000);

    for (int k = 0; k < 4; k++) begin
      last_head[k] = '0;
      mcnt[k] = 0;
    end

    for (int i = 0; i < 22; i++) begin
      rst           = tv[i].r;
      bus.in_valid  = tv[i].iv;
      bus.in_sel    = tv[i].sel;
      bus.in_data   = tv[i].data;
      bus.out_ready = tv[i].ordy;
      cnt_clr       = tv[i].clr;
      #1;
      chk($sformatf("row%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, tv[i].exp_rdy});
      cycle(acc);
      chk($sformatf("row%0d_out_valid", i), {28'd0, bus.out_valid}, {28'd0, tv[i].exp_ov});
      chk($sformatf("row%0d_data", i), {bus.d, bus.c, bus.b, bus.a}, tv[i].exp_data);
      chk($sformatf("row%0d_cnt", i), {16'd0, cnt_d, cnt_c, cnt_b, cnt_a}, {16'd0, tv[i].exp_cnt});
    end

    // Random stream against the per-channel queue model.
    words = 0;
    cyc   = 0;
    rst     = 1'b0;
    cnt_clr = 1'b0;
    while (words < 200 && cyc < 5000) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_sel    = 2'($urandom_range(0, 3));
      bus.in_data   = 8'($urandom);
      bus.out_ready = 4'($urandom_range(0, 15));
      #1;
      chk("rnd_in_ready", {31'd0, bus.in_ready}, {31'd0, (mq[bus.in_sel].size() < 2)});
      cycle(acc);
      if (acc) words++;
      cyc++;
      model_compare("rnd");
    end
    chk("rnd_word_budget", {31'd0, (words >= 200)}, 32'd1);

    bus.in_valid  = 1'b0;
    bus.out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      cycle(acc);
      model_compare("drain");
    end
    chk("drain_empty", {28'd0, bus.out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
